// File: rtl/gpu_pkg.sv
// Shared definitions for the miniGPU core-interface blocks: dispatcher state,
// per-core field width and block-count arithmetic.
package gpu_pkg;

  localparam int CORE_FIELD_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DONE     = 2'd2
  } state_e;

  function automatic logic [31:0] ceil_div(input logic [31:0] n, input logic [31:0] d);
    logic [31:0] q;
    q = n / d;
    if ((n % d) != 32'd0) q = q + 32'd1;
    return q;
  endfunction

endpackage

// File: rtl/kernel_dispatcher_picker.sv
// Priority encoder returning the lowest-index core that is neither running a
// block nor serving its one-cycle retirement reset.
module idle_core_picker #(
  parameter int NUM_CORES = 2,
  parameter int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic [NUM_CORES-1:0] active_mask,
  input  logic [NUM_CORES-1:0] retired_mask,
  output logic                 found,
  output logic [IDX_W-1:0]     idx
);

  logic [NUM_CORES-1:0] eligible;

  assign eligible = ~(active_mask | retired_mask);

  // Scan high to low so the lowest eligible index is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/kernel_dispatcher.sv
// Kernel launch dispatcher: splits a launch into blocks, hands them to idle
// cores one per cycle, retires finished cores and reports kernel completion.
module kernel_dispatcher
  import gpu_pkg::*;
#(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int TC_BITS           = 16,
  parameter int BID_BITS          = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             launch_valid,
  input  logic [TC_BITS-1:0]               launch_thread_count,
  output logic                             launch_ready,
  output logic                             busy,
  output logic                             done,
  output logic [31:0]                      kernel_cycles,
  input  logic [NUM_CORES-1:0]             core_done,
  output logic [NUM_CORES-1:0]             core_start,
  output logic [NUM_CORES-1:0]             core_reset,
  output logic [BID_BITS*NUM_CORES-1:0]    core_block_id_flat,
  output logic [CORE_FIELD_W*NUM_CORES-1:0] core_thread_count_flat
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [TC_BITS-1:0]      TPB_TC    = TC_BITS'(THREADS_PER_BLOCK);
  localparam logic [CORE_FIELD_W-1:0] TPB_FIELD = CORE_FIELD_W'(THREADS_PER_BLOCK);

  state_e               state;
  logic [TC_BITS-1:0]   count_q;
  logic [TC_BITS-1:0]   total_blocks;
  logic [TC_BITS-1:0]   dispatched;
  logic [TC_BITS-1:0]   retired;

  logic [NUM_CORES-1:0] retiring;
  logic [NUM_CORES-1:0] assign_mask;
  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic                 can_assign;
  logic [TC_BITS-1:0]   retired_next;
  logic [TC_BITS-1:0]   last_tc;
  logic [CORE_FIELD_W-1:0] blk_tc;

  function automatic logic [TC_BITS-1:0] count_ones(input logic [NUM_CORES-1:0] m);
    logic [TC_BITS-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CORES; i++) n = n + TC_BITS'(m[i]);
    return n;
  endfunction

  // Outside DISPATCH core_reset is all ones, but the picker result is only
  // used in DISPATCH where core_reset carries just the retirement pulses.
  idle_core_picker #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_picker (
    .active_mask  (core_start),
    .retired_mask (core_reset),
    .found        (pick_found),
    .idx          (pick_idx)
  );

  assign retiring     = core_done & core_start;
  assign retired_next = retired + count_ones(retiring);
  assign can_assign   = (state == DISPATCH) && (dispatched < total_blocks) && pick_found;
  assign assign_mask  = can_assign ? (NUM_CORES'(1) << pick_idx) : '0;
  assign last_tc      = count_q - (total_blocks - TC_BITS'(1)) * TPB_TC;
  assign blk_tc       = (dispatched == total_blocks - TC_BITS'(1)) ? CORE_FIELD_W'(last_tc)
                                                                   : TPB_FIELD;

  always_ff @(posedge clk) begin
    if (reset) begin
      state                  <= IDLE;
      launch_ready           <= 1'b1;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      kernel_cycles          <= '0;
      core_start             <= '0;
      core_reset             <= '1;
      core_block_id_flat     <= '0;
      core_thread_count_flat <= '0;
      count_q                <= '0;
      total_blocks           <= '0;
      dispatched             <= '0;
      retired                <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          core_reset <= '1;
          if (launch_valid && launch_ready) begin
            count_q       <= launch_thread_count;
            total_blocks  <= TC_BITS'(ceil_div(32'(launch_thread_count),
                                               32'(THREADS_PER_BLOCK)));
            dispatched    <= '0;
            retired       <= '0;
            kernel_cycles <= '0;
            launch_ready  <= 1'b0;
            busy          <= 1'b1;
            if (launch_thread_count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= DISPATCH;
              core_reset <= '0;
            end
          end
        end
        DISPATCH: begin
          if (kernel_cycles != '1) kernel_cycles <= kernel_cycles + 32'd1;
          core_start <= (core_start & ~retiring) | assign_mask;
          core_reset <= retiring;
          for (int i = 0; i < NUM_CORES; i++) begin
            if (assign_mask[i]) begin
              core_block_id_flat[i*BID_BITS +: BID_BITS]             <= BID_BITS'(dispatched);
              core_thread_count_flat[i*CORE_FIELD_W +: CORE_FIELD_W] <= blk_tc;
            end
          end
          dispatched <= dispatched + TC_BITS'(can_assign);
          retired    <= retired_next;
          if (retired_next == total_blocks) begin
            state      <= DONE;
            done       <= 1'b1;
            core_reset <= '1;
          end
        end
        DONE: begin
          state        <= IDLE;
          launch_ready <= 1'b1;
          busy         <= 1'b0;
          core_reset   <= '1;
        end
        default: begin
          state        <= IDLE;
          launch_ready <= 1'b1;
          busy         <= 1'b0;
          core_reset   <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_dispatcher.sv
// Directed bench for kernel_dispatcher with 2 cores and 4 threads per block;
// cores are either a fixed-latency model or driven by hand.
module tb_kernel_dispatcher;

  localparam int LAT = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        launch_valid;
  logic [15:0] launch_thread_count;
  logic        launch_ready;
  logic        busy;
  logic        done;
  logic [31:0] kernel_cycles;
  logic [1:0]  core_done;
  logic [1:0]  core_start;
  logic [1:0]  core_reset;
  logic [15:0] core_block_id_flat;
  logic [15:0] core_thread_count_flat;

  logic        auto_en;
  logic [1:0]  auto_done;
  logic [1:0]  man_done;
  int          cnt [2];
  int          chk  = 0;
  int          pass = 0;

  kernel_dispatcher #(
    .NUM_CORES(2), .THREADS_PER_BLOCK(4), .TC_BITS(16), .BID_BITS(8)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .launch_valid           (launch_valid),
    .launch_thread_count    (launch_thread_count),
    .launch_ready           (launch_ready),
    .busy                   (busy),
    .done                   (done),
    .kernel_cycles          (kernel_cycles),
    .core_done              (core_done),
    .core_start             (core_start),
    .core_reset             (core_reset),
    .core_block_id_flat     (core_block_id_flat),
    .core_thread_count_flat (core_thread_count_flat)
  );

  always #5 clk = ~clk;

  assign core_done = auto_en ? auto_done : man_done;

  // Each modelled core raises done for one cycle, LAT cycles after start rises.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (core_start[i] === 1'b1) begin
        cnt[i] = cnt[i] + 1;
        auto_done[i] = (cnt[i] == LAT);
      end else begin
        cnt[i] = 0;
        auto_done[i] = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_launch(input logic [15:0] n);
    launch_valid = 1'b1;
    launch_thread_count = n;
    @(posedge clk);
    @(negedge clk);
    launch_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; launch_valid = 1'b0; launch_thread_count = '0;
    auto_en = 1'b0; man_done = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk++; if (launch_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", launch_ready); else pass++;
    chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass++;
    chk++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else pass++;
    chk++; if (kernel_cycles !== 32'd0) $display("FAIL rst_cycles: got %0d want 0", kernel_cycles); else pass++;
    chk++; if (core_start !== 2'b00) $display("FAIL rst_start: got %b want 00", core_start); else pass++;
    chk++; if (core_reset !== 2'b11) $display("FAIL rst_core_reset: got %b want 11", core_reset); else pass++;
    chk++; if (core_block_id_flat !== 16'h0) $display("FAIL rst_bid: got %h want 0000", core_block_id_flat); else pass++;
    chk++; if (core_thread_count_flat !== 16'h0) $display("FAIL rst_tc: got %h want 0000", core_thread_count_flat); else pass++;
    reset = 1'b0;
  endtask

  task automatic test_full_blocks();
    int dones = 0;
    auto_en = 1'b1;
    do_launch(16'd8);
    chk++; if (launch_ready !== 1'b0 || busy !== 1'b1) $display("FAIL t1_accept: got ready=%b busy=%b want 0 1", launch_ready, busy); else pass++;
    chk++; if (core_reset !== 2'b00) $display("FAIL t1_release: got %b want 00", core_reset); else pass++;
    for (int k = 1; k <= 13; k++) begin
      step();
      if (done === 1'b1) dones++;
      if (k == 1) begin
        chk++; if (core_start !== 2'b01) $display("FAIL t1_start0: got %b want 01", core_start); else pass++;
        chk++; if (core_block_id_flat[7:0] !== 8'd0 || core_thread_count_flat[7:0] !== 8'd4) $display("FAIL t1_blk0: got id=%0d tc=%0d want 0 4", core_block_id_flat[7:0], core_thread_count_flat[7:0]); else pass++;
      end
      if (k == 2) begin
        chk++; if (core_start !== 2'b11) $display("FAIL t1_start1: got %b want 11", core_start); else pass++;
        chk++; if (core_block_id_flat[15:8] !== 8'd1 || core_thread_count_flat[15:8] !== 8'd4) $display("FAIL t1_blk1: got id=%0d tc=%0d want 1 4", core_block_id_flat[15:8], core_thread_count_flat[15:8]); else pass++;
      end
      if (k == 11) begin
        chk++; if (core_start !== 2'b10 || core_reset !== 2'b01) $display("FAIL t1_retire0: got start=%b rst=%b want 10 01", core_start, core_reset); else pass++;
      end
      if (k == 12) begin
        chk++; if (done !== 1'b1 || core_reset !== 2'b11) $display("FAIL t1_done: got done=%b rst=%b want 1 11", done, core_reset); else pass++;
        chk++; if (kernel_cycles !== 32'd12) $display("FAIL t1_cycles: got %0d want 12", kernel_cycles); else pass++;
      end
      if (k == 13) begin
        chk++; if (done !== 1'b0 || launch_ready !== 1'b1 || busy !== 1'b0) $display("FAIL t1_idle: got done=%b ready=%b busy=%b want 0 1 0", done, launch_ready, busy); else pass++;
      end
    end
    chk++; if (dones != 1) $display("FAIL t1_done_count: got %0d want 1", dones); else pass++;
  endtask

  task automatic test_partial_block();
    auto_en = 1'b1;
    do_launch(16'd10);
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k == 2) begin
        chk++; if (core_start !== 2'b11 || core_thread_count_flat !== 16'h0404) $display("FAIL t2_first: got start=%b tc=%h want 11 0404", core_start, core_thread_count_flat); else pass++;
      end
      if (k == 12) begin
        chk++; if (core_start !== 2'b00 || core_reset !== 2'b10) $display("FAIL t2_gap: got start=%b rst=%b want 00 10", core_start, core_reset); else pass++;
      end
      if (k == 13) begin
        chk++; if (core_start !== 2'b01) $display("FAIL t2_reissue: got %b want 01", core_start); else pass++;
        chk++; if (core_block_id_flat[7:0] !== 8'd2 || core_thread_count_flat[7:0] !== 8'd2) $display("FAIL t2_last_blk: got id=%0d tc=%0d want 2 2", core_block_id_flat[7:0], core_thread_count_flat[7:0]); else pass++;
      end
      if (k == 23) begin
        chk++; if (done !== 1'b1 || kernel_cycles !== 32'd23) $display("FAIL t2_done: got done=%b cycles=%0d want 1 23", done, kernel_cycles); else pass++;
      end
      if (k == 24) begin
        chk++; if (launch_ready !== 1'b1) $display("FAIL t2_ready: got %b want 1", launch_ready); else pass++;
      end
    end
  endtask

  task automatic test_zero_count();
    auto_en = 1'b1;
    do_launch(16'd0);
    chk++; if (done !== 1'b1 || busy !== 1'b1 || launch_ready !== 1'b0) $display("FAIL t3_done: got done=%b busy=%b ready=%b want 1 1 0", done, busy, launch_ready); else pass++;
    chk++; if (kernel_cycles !== 32'd0 || core_start !== 2'b00) $display("FAIL t3_state: got cycles=%0d start=%b want 0 00", kernel_cycles, core_start); else pass++;
    step();
    chk++; if (done !== 1'b0 || launch_ready !== 1'b1 || core_start !== 2'b00) $display("FAIL t3_idle: got done=%b ready=%b start=%b want 0 1 00", done, launch_ready, core_start); else pass++;
  endtask

  task automatic test_dual_retire();
    auto_en = 1'b0; man_done = '0;
    do_launch(16'd12);
    for (int k = 1; k <= 9; k++) begin
      step();
      man_done = (k == 4) ? 2'b11 : (k == 7) ? 2'b01 : 2'b00;
      if (k == 5) begin
        chk++; if (core_start !== 2'b00 || core_reset !== 2'b11 || done !== 1'b0) $display("FAIL t4_both: got start=%b rst=%b done=%b want 00 11 0", core_start, core_reset, done); else pass++;
      end
      if (k == 6) begin
        chk++; if (core_start !== 2'b00 || core_reset !== 2'b00) $display("FAIL t4_hold: got start=%b rst=%b want 00 00", core_start, core_reset); else pass++;
      end
      if (k == 7) begin
        chk++; if (core_start !== 2'b01 || core_block_id_flat[7:0] !== 8'd2 || core_thread_count_flat[7:0] !== 8'd4) $display("FAIL t4_reissue: got start=%b id=%0d tc=%0d want 01 2 4", core_start, core_block_id_flat[7:0], core_thread_count_flat[7:0]); else pass++;
      end
      if (k == 8) begin
        chk++; if (done !== 1'b1 || kernel_cycles !== 32'd8) $display("FAIL t4_done: got done=%b cycles=%0d want 1 8", done, kernel_cycles); else pass++;
      end
      if (k == 9) begin
        chk++; if (launch_ready !== 1'b1) $display("FAIL t4_ready: got %b want 1", launch_ready); else pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    auto_en = 1'b0; man_done = '0;
    launch_valid = 1'b1;
    launch_thread_count = 16'd4;
    @(posedge clk);
    @(negedge clk);
    launch_thread_count = 16'd5;
    for (int k = 1; k <= 6; k++) begin
      step();
      man_done = (k == 1) ? 2'b10 : (k == 3) ? 2'b01 : 2'b00;
      if (k == 2) begin
        chk++; if (core_start !== 2'b01 || core_reset !== 2'b00 || done !== 1'b0) $display("FAIL t5_spurious: got start=%b rst=%b done=%b want 01 00 0", core_start, core_reset, done); else pass++;
        chk++; if (launch_ready !== 1'b0 || busy !== 1'b1) $display("FAIL t5_ignored: got ready=%b busy=%b want 0 1", launch_ready, busy); else pass++;
      end
      if (k == 4) begin
        chk++; if (done !== 1'b1 || kernel_cycles !== 32'd4) $display("FAIL t5_done: got done=%b cycles=%0d want 1 4", done, kernel_cycles); else pass++;
      end
      if (k == 5) begin
        chk++; if (launch_ready !== 1'b1 || busy !== 1'b0) $display("FAIL t5_idle: got ready=%b busy=%b want 1 0", launch_ready, busy); else pass++;
      end
      if (k == 6) begin
        chk++; if (launch_ready !== 1'b0 || busy !== 1'b1 || kernel_cycles !== 32'd0) $display("FAIL t5_second: got ready=%b busy=%b cycles=%0d want 0 1 0", launch_ready, busy, kernel_cycles); else pass++;
        launch_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    step();
    chk++; if (core_start !== 2'b01 || core_thread_count_flat[7:0] !== 8'd4) $display("FAIL t6_blk0: got start=%b tc=%0d want 01 4", core_start, core_thread_count_flat[7:0]); else pass++;
    step();
    chk++; if (core_start !== 2'b11 || core_block_id_flat[15:8] !== 8'd1 || core_thread_count_flat[15:8] !== 8'd1) $display("FAIL t6_blk1: got start=%b id=%0d tc=%0d want 11 1 1", core_start, core_block_id_flat[15:8], core_thread_count_flat[15:8]); else pass++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk++; if (core_start !== 2'b00 || core_reset !== 2'b11) $display("FAIL t6_cores: got start=%b rst=%b want 00 11", core_start, core_reset); else pass++;
    chk++; if (launch_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) $display("FAIL t6_ctrl: got ready=%b busy=%b done=%b want 1 0 0", launch_ready, busy, done); else pass++;
    chk++; if (kernel_cycles !== 32'd0 || core_block_id_flat !== 16'h0 || core_thread_count_flat !== 16'h0) $display("FAIL t6_data: got cycles=%0d bid=%h tc=%h want 0 0000 0000", kernel_cycles, core_block_id_flat, core_thread_count_flat); else pass++;
    for (int k = 0; k < 5; k++) begin
      step();
      if (done === 1'b1 || busy !== 1'b0) dones++;
    end
    chk++; if (dones != 0) $display("FAIL t6_no_done: got %0d active cycles want 0", dones); else pass++;
  endtask

  initial begin
    test_reset();
    test_full_blocks();
    test_partial_block();
    test_zero_count();
    test_dual_retire();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
